// File: rtl/classify_ctrl_pkg.sv
// Shared types for the pixel classifier sequencer: FSM state encoding
// and the 2-bit classification codes written into the mask buffer.
package classify_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      TRAIN    = 2'd2,
      DETECT   = 2'd3
   } ctrl_state_t;

   typedef enum logic [1:0] {
      BG        = 2'd0,
      FG        = 2'd1,
      SHADOW    = 2'd2,
      HIGHLIGHT = 2'd3
   } class_code_t;

endpackage

// File: rtl/classify_ctrl_if.sv
// Camera pixel stream bundle: strobe, start-of-frame marker and {R,G,B}.
// The camera front end drives it (master); the sequencer consumes it (slave).
interface classify_ctrl_if;
   logic        valid;
   logic        sof;
   logic [23:0] rgb;

   modport master (output valid, sof, rgb);
   modport slave  (input  valid, sof, rgb);
endinterface

// File: rtl/classify_ctrl_delay_line.sv
// Fixed-depth register pipeline used to align pixel side-band data with the
// model BRAM read data and with the classifier result. Reset clears every
// stage so nothing in flight survives a reset.
module delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage [DEPTH];

   // shift one stage per clock
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/classify_ctrl.sv
// Frame-level sequencer for the background-subtraction classifier.
// Trains the background model for TRAIN_FRAMES frames, then in detection
// issues model reads, aligns pixels with model data, feeds the classifier
// and writes each 2-bit result into the mask buffer.
// Optional build macro CLASSIFY_CTRL_STATS_EN adds fg_count_out, the number
// of FG mask writes in the most recently completed detection frame.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | stopped; pixels ignored, waits for start_in
// WAIT_SOF | armed; waits for sof to enter TRAIN (or DETECT once trained)
// TRAIN    | pixels go to the model updater, frames counted
// DETECT   | pixels read the model and flow through the classifier
module classify_ctrl
   import classify_pkg::*;
#(
   parameter int H_PIXELS     = 320,
   parameter int V_PIXELS     = 240,
   parameter int TRAIN_FRAMES = 16,
   parameter int MODEL_RD_LAT = 2,
   parameter int CLASS_LAT    = 2,
   parameter int ADDR_W       = $clog2(H_PIXELS*V_PIXELS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic              stop_in,
   classify_ctrl_if.slave    pix,
   output logic              model_rd_en_out,
   output logic [ADDR_W-1:0] model_addr_out,
   output logic              train_valid_out,
   output logic [ADDR_W-1:0] train_addr_out,
   output logic              class_valid_out,
   output logic [23:0]       class_rgb_out,
   input  logic [1:0]        class_result_in,
   output logic              mask_we_out,
   output logic [ADDR_W-1:0] mask_addr_out,
   output logic [1:0]        mask_data_out,
   output logic [1:0]        state_out,
   output logic              frame_done_out,
   output logic              overrun_out
`ifdef CLASSIFY_CTRL_STATS_EN
   ,output logic [ADDR_W:0]  fg_count_out
`endif
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS*V_PIXELS - 1);
   localparam int                FC_W      = (TRAIN_FRAMES > 1) ? $clog2(TRAIN_FRAMES) : 1;
   localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(TRAIN_FRAMES - 1);
   localparam int                MP_W      = 1 + 24 + ADDR_W;
   localparam int                CP_W      = 1 + ADDR_W;

   ctrl_state_t       state;
   logic [ADDR_W-1:0] cur_addr;
   logic [FC_W-1:0]   frame_cnt;
   logic              trained;
   logic              stop_flag;
   logic              ended;

   logic              in_run;
   logic              sof_go;
   logic              accept;
   logic              acc_train;
   logic              acc_detect;
   logic              frame_end;
   logic              early_sof;
   logic              dropped;
   logic [ADDR_W-1:0] pix_addr;

   // pixel acceptance and address of the current pixel
   always_comb begin
      pix_addr   = pix.sof ? '0 : cur_addr;
      in_run     = (state == TRAIN) || (state == DETECT);
      sof_go     = (state == WAIT_SOF) && pix.valid && pix.sof && !stop_in;
      accept     = in_run && pix.valid && (pix.sof || !ended);
      acc_train  = ((state == TRAIN) && accept) || (sof_go && !trained);
      acc_detect = ((state == DETECT) && accept) || (sof_go && trained);
      frame_end  = accept && (pix_addr == LAST_ADDR);
      early_sof  = accept && pix.sof && (cur_addr != '0);
      dropped    = in_run && pix.valid && !pix.sof && ended;
   end

   assign train_valid_out = acc_train;
   assign train_addr_out  = acc_train ? pix_addr : '0;
   assign model_rd_en_out = acc_detect;
   assign model_addr_out  = acc_detect ? pix_addr : '0;
   assign state_out       = state;

   // sequencer FSM: state, pixel/frame counters, stop arming, overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cur_addr       <= '0;
         frame_cnt      <= '0;
         trained        <= 1'b0;
         stop_flag      <= 1'b0;
         ended          <= 1'b0;
         frame_done_out <= 1'b0;
         overrun_out    <= 1'b0;
      end else begin
         frame_done_out <= frame_end;
         case (state)
            IDLE: begin
               if (start_in) begin
                  state       <= WAIT_SOF;
                  overrun_out <= 1'b0;
                  frame_cnt   <= '0;
                  trained     <= 1'b0;
                  stop_flag   <= 1'b0;
                  cur_addr    <= '0;
                  ended       <= 1'b0;
               end
            end
            WAIT_SOF: begin
               if (stop_in) begin
                  state <= IDLE;
               end else if (sof_go) begin
                  state    <= trained ? DETECT : TRAIN;
                  cur_addr <= ADDR_W'(1);
                  ended    <= 1'b0;
               end
            end
            TRAIN, DETECT: begin
               if (stop_in) stop_flag <= 1'b1;
               if (early_sof || dropped) overrun_out <= 1'b1;
               if (accept) begin
                  if (frame_end) begin
                     cur_addr <= '0;
                     ended    <= 1'b1;
                     if (stop_flag || stop_in) begin
                        state <= IDLE;
                     end else if (state == TRAIN) begin
                        if (frame_cnt == FC_LAST) begin
                           state     <= WAIT_SOF;
                           trained   <= 1'b1;
                           frame_cnt <= '0;
                        end else begin
                           frame_cnt <= frame_cnt + 1'b1;
                        end
                     end
                  end else begin
                     cur_addr <= pix_addr + 1'b1;
                     ended    <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [MP_W-1:0]   model_pipe_q;
   logic [CP_W-1:0]   class_pipe_q;
   logic [ADDR_W-1:0] class_addr;
   logic [23:0]       model_rgb;

   assign model_rgb = acc_detect ? pix.rgb : 24'd0;

   delay_line #(.WIDTH(MP_W), .DEPTH(MODEL_RD_LAT)) u_model_align (
      .clk  (clk),
      .rst  (rst),
      .din  ({acc_detect, model_rgb, model_addr_out}),
      .dout (model_pipe_q)
   );

   assign {class_valid_out, class_rgb_out, class_addr} = model_pipe_q;

   // classifier output qualified by our own delayed valid, not its valid_out
   delay_line #(.WIDTH(CP_W), .DEPTH(CLASS_LAT)) u_class_align (
      .clk  (clk),
      .rst  (rst),
      .din  ({class_valid_out, class_addr}),
      .dout (class_pipe_q)
   );

   assign {mask_we_out, mask_addr_out} = class_pipe_q;
   assign mask_data_out = mask_we_out ? class_result_in : 2'b00;

`ifdef CLASSIFY_CTRL_STATS_EN
   logic [ADDR_W:0] fg_cnt;
   logic [ADDR_W:0] fg_next;
   logic            is_fg;

   // frame boundaries taken at the mask side so the count matches the writes
   always_comb begin
      is_fg   = mask_we_out && (mask_data_out == 2'(FG));
      fg_next = ((mask_addr_out == '0) ? '0 : fg_cnt) + (ADDR_W+1)'(is_fg);
   end

   // per-frame FG counter, published after the frame's last mask write
   always_ff @(posedge clk) begin
      if (rst) begin
         fg_cnt       <= '0;
         fg_count_out <= '0;
      end else if (mask_we_out) begin
         fg_cnt <= fg_next;
         if (mask_addr_out == LAST_ADDR) fg_count_out <= fg_next;
      end
   end
`endif

endmodule

// File: doc/classify_ctrl.md
# classify_ctrl

Frame-level sequencer for the background-subtraction pixel classifier. It takes the camera pixel stream, first runs a background-training phase of a fixed number of frames, then switches to detection. In detection it issues background-model reads, aligns each pixel with its model word, drives the classifier, and writes each 2-bit result into the mask buffer at the correct address. It sits between the camera front end, the model BRAM, the classifier, and the mask BRAM.

## Interface
- H_PIXELS, 320, active pixels per line
- V_PIXELS, 240, active lines per frame
- TRAIN_FRAMES, 16, frames in training phase (≥1)
- MODEL_RD_LAT, 2, model BRAM read latency in cycles (≥1)
- CLASS_LAT, 2, classifier latency from valid_in to result (≥1)
- ADDR_W, $clog2(H_PIXELS*V_PIXELS), pixel address width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle pulse: begin training
- stop_in  in  1  one-cycle pulse: stop after current frame
- pix_valid_in  in  1  pixel strobe; gaps allowed
- pix_sof_in  in  1  first pixel of frame, qualified by pix_valid_in
- pix_rgb_in  in  24  {R,G,B}
- model_rd_en_out  out  1  model BRAM read enable
- model_addr_out  out  ADDR_W  model BRAM read address
- train_valid_out  out  1  pixel to model updater (TRAIN only)
- train_addr_out  out  ADDR_W  updater address
- class_valid_out  out  1  classifier valid_in
- class_rgb_out  out  24  classifier I_R/I_G/I_B, aligned with model read data
- class_result_in  in  2  classifier classification
- mask_we_out  out  1  mask BRAM write enable
- mask_addr_out  out  ADDR_W  mask write address
- mask_data_out  out  2  mask write data
- state_out  out  2  current FSM state
- frame_done_out  out  1  one-cycle pulse at end of each frame
- overrun_out  out  1  sticky framing error, cleared by start_in

## Operation
- States: IDLE=0, WAIT_SOF=1, TRAIN=2, DETECT=3.
- IDLE → WAIT_SOF on start_in. start_in in any other state is ignored.
- WAIT_SOF → TRAIN on pix_valid_in && pix_sof_in. That pixel is accepted as address 0.
- Pixel address counter: resets to 0 on an accepted sof and increments on each accepted pixel.
- Frame end is the accepted pixel at address H_PIXELS*V_PIXELS-1. It pulses frame_done_out on the following cycle.
- TRAIN:
  - Each accepted pixel drives train_valid_out/train_addr_out combinationally with pix_valid_in.
  - The frame counter increments at each frame end.
  - After TRAIN_FRAMES frames → WAIT_SOF, then into DETECT on the next sof.
- DETECT:
  - Each accepted pixel asserts model_rd_en_out/model_addr_out in the same cycle.
  - {valid, rgb, addr} travel through a MODEL_RD_LAT-deep shift register, which emerges as class_valid_out/class_rgb_out.
  - {valid, addr} continue through a CLASS_LAT-deep shift register.
  - At its output: mask_we_out=1, mask_addr_out=addr, mask_data_out=class_result_in.
- Mask write qualification uses the internal delayed valid only, never the classifier's valid_out.
- stop_in:
  - Arms a stop flag.
  - At the next frame end the FSM goes to IDLE.
  - Shift registers drain, so in-flight mask writes still complete.
  - stop_in in WAIT_SOF goes to IDLE immediately.
- Early sof (sof while address ≠ 0 in TRAIN/DETECT):
  - Sets overrun_out.
  - Restarts the address counter at 0 with that pixel.
  - Frame counter unchanged.
- Pixels after frame end and before the next sof are dropped and set overrun_out.
- Pixels in IDLE are ignored.
- Pixels in WAIT_SOF without sof are ignored, with no overrun.
- Simultaneous stop_in and frame end: stop takes effect at that frame end.

## Timing
- Reset values:
  - state_out=IDLE
  - all valid/enable/pulse outputs 0
  - addresses 0, mask_data_out 0, class_rgb_out 0
  - overrun_out 0
  - counters 0, shift registers cleared
- Latency from accepted pixel:
  - model read: 0 cycles
  - class_valid_out: MODEL_RD_LAT cycles
  - mask_we_out: MODEL_RD_LAT+CLASS_LAT cycles
- Sustains 1 pixel/cycle with no backpressure.
- Reset mid-frame clears all state. Pipeline contents are discarded and no further mask writes occur.

## Configuration
- CLASSIFY_CTRL_STATS_EN defined:
  - Adds fg_count_out (ADDR_W+1 bits, reset 0).
  - Counts mask writes with data==2'b01 within a DETECT frame.
  - Latched on the cycle after the frame's last mask write.
  - Internal counter cleared at frame start.
- Not defined: port and counter absent.

## Structure
- Package classify_pkg holds:
  - typedef enum ctrl_state_t {IDLE, WAIT_SOF, TRAIN, DETECT}
  - class codes: BG=0, FG=1, SHADOW=2, HIGHLIGHT=3
- Sub-module delay_line (parameters WIDTH, DEPTH) is instantiated for both alignment pipelines.

## Test plan
- Reset, then 5 idle cycles: state_out=0 and all outputs 0.
- H=4, V=2, TRAIN_FRAMES=2; start, then 2 continuous frames: 16 train_valid_out pulses with addresses 0..7 twice, 2 frame_done_out pulses, state reaches WAIT_SOF and then DETECT on the next sof.
- DETECT frame with a 1-cycle gap after every pixel, classifier model returning addr[1:0]: 8 mask writes at addresses 0..7 with data addr[1:0], each exactly MODEL_RD_LAT+CLASS_LAT after its pixel.
- sof at address 5 in DETECT: overrun_out=1 and the next mask address is 0. A subsequent start_in from IDLE clears overrun_out.
- stop_in at address 3: the frame completes, the last mask write goes to address 7, then state=IDLE and no further writes.
- With CLASSIFY_CTRL_STATS_EN, a frame where 3 results equal FG: fg_count_out=3 after the frame's final write.
